// File: rtl/svf_mux.sv
// Time-multiplexed multi-channel state-variable filter with one shared multiplier.
// Each frame runs HP/BP/LP steps per channel, then mixes, applies volume and emits one sample.
module svf_mux #(
    parameter int CHANNELS = 3,
    parameter int IN_W     = 8,
    parameter int STATE_W  = 16,
    parameter int FC_W     = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CHANNELS*IN_W-1:0] in_sample,
    input  logic [FC_W-1:0]          fc,
    input  logic [3:0]               res,
    input  logic [2:0]               mode,
    input  logic [CHANNELS-1:0]      filt_en,
    input  logic [3:0]               vol,
    output logic                     out_valid,
    output logic [IN_W-1:0]          out_sample
);

    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int ACC_W   = STATE_W + $clog2(CHANNELS) + 2;
    localparam int MUL_B_W = FC_W + 1;
    localparam int PROD_W  = STATE_W + MUL_B_W;
    localparam int SUM_W   = PROD_W + 2;

    localparam logic signed [STATE_W-1:0] ST_MAX  = {1'b0, {(STATE_W-1){1'b1}}};
    localparam logic signed [STATE_W-1:0] ST_MIN  = {1'b1, {(STATE_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0]   OUT_MID = SUM_W'(2 ** (IN_W - 1));
    localparam logic signed [SUM_W-1:0]   OUT_MAX = SUM_W'((2 ** IN_W) - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HP,
        ST_BP,
        ST_LP,
        ST_MIX,
        ST_VOL
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [CHANNELS*IN_W-1:0] r_sample;
    logic [FC_W-1:0]          r_fc;
    logic [3:0]               r_q;
    logic [2:0]               r_mode;
    logic [CHANNELS-1:0]      r_filtEn;
    logic [3:0]               r_vol;
    logic [CH_W-1:0]          r_ch;

    logic signed [STATE_W-1:0] r_bp [CHANNELS];
    logic signed [STATE_W-1:0] r_lp [CHANNELS];
    logic signed [STATE_W-1:0] r_hp;
    logic signed [STATE_W-1:0] r_bpNew;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [STATE_W-1:0] r_mix;
    logic [IN_W-1:0]           r_outSample;
    logic                      r_outValid;

    logic [IN_W-1:0]           w_chSample [CHANNELS];
    logic [IN_W-1:0]           w_sampleCur;
    logic signed [STATE_W-1:0] w_sIn;
    logic signed [STATE_W-1:0] w_bpCur;
    logic signed [STATE_W-1:0] w_lpCur;
    logic                      w_bypass;
    logic                      w_lastCh;

    logic signed [STATE_W-1:0] w_mulA;
    logic signed [MUL_B_W-1:0] w_mulB;
    logic signed [PROD_W-1:0]  w_prod;

    logic signed [SUM_W-1:0]   w_hpSum;
    logic signed [SUM_W-1:0]   w_bpSum;
    logic signed [SUM_W-1:0]   w_lpSum;
    logic signed [STATE_W-1:0] w_hpSat;
    logic signed [STATE_W-1:0] w_bpSat;
    logic signed [STATE_W-1:0] w_lpSat;
    logic signed [STATE_W-1:0] w_lpSel;
    logic signed [STATE_W-1:0] w_bpSel;
    logic signed [STATE_W-1:0] w_hpSel;
    logic signed [ACC_W-1:0]   w_contrib;
    logic signed [SUM_W-1:0]   w_volSum;
    logic [IN_W-1:0]           w_outClamp;

    function automatic logic signed [STATE_W-1:0] satState(input logic signed [SUM_W-1:0] x);
        if (x > SUM_W'(ST_MAX)) begin
            satState = ST_MAX;
        end else if (x < SUM_W'(ST_MIN)) begin
            satState = ST_MIN;
        end else begin
            satState = x[STATE_W-1:0];
        end
    endfunction

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            w_chSample[k] = r_sample[k*IN_W +: IN_W];
        end
    end

    assign w_sampleCur = w_chSample[r_ch];
    // Inverting the MSB of an offset-binary sample subtracts the midpoint.
    assign w_sIn    = {{(STATE_W-IN_W+1){~w_sampleCur[IN_W-1]}}, w_sampleCur[IN_W-2:0]};
    assign w_bpCur  = r_bp[r_ch];
    assign w_lpCur  = r_lp[r_ch];
    assign w_bypass = ~r_filtEn[r_ch] | (r_mode == 3'b000);
    assign w_lastCh = (r_ch == CH_W'(CHANNELS - 1));

    always_comb begin
        w_mulA = w_bpCur;
        w_mulB = {{(MUL_B_W-4){1'b0}}, r_q};
        case (r_state)
            ST_BP: begin
                w_mulA = r_hp;
                w_mulB = {1'b0, r_fc};
            end
            ST_LP: begin
                w_mulA = r_bpNew;
                w_mulB = {1'b0, r_fc};
            end
            ST_VOL: begin
                w_mulA = r_mix;
                w_mulB = {{(MUL_B_W-4){1'b0}}, r_vol};
            end
            default: ;
        endcase
    end

    assign w_prod = PROD_W'(w_mulA) * PROD_W'(w_mulB);

    assign w_hpSum = SUM_W'(w_sIn) - SUM_W'(w_lpCur) - SUM_W'(w_prod >>> 3);
    assign w_bpSum = SUM_W'(w_bpCur) + SUM_W'(w_prod >>> (FC_W + 1));
    assign w_lpSum = SUM_W'(w_lpCur) + SUM_W'(w_prod >>> (FC_W + 1));
    assign w_hpSat = satState(w_hpSum);
    assign w_bpSat = satState(w_bpSum);
    assign w_lpSat = satState(w_lpSum);

    assign w_lpSel   = r_mode[0] ? w_lpSat : '0;
    assign w_bpSel   = r_mode[1] ? r_bpNew : '0;
    assign w_hpSel   = r_mode[2] ? r_hp    : '0;
    assign w_contrib = w_bypass ? ACC_W'(w_sIn)
                                : ACC_W'(w_lpSel) + ACC_W'(w_bpSel) + ACC_W'(w_hpSel);

    assign w_volSum = SUM_W'(w_prod >>> 4) + OUT_MID;

    always_comb begin
        w_outClamp = w_volSum[IN_W-1:0];
        if (w_volSum < 0) begin
            w_outClamp = '0;
        end else if (w_volSum > OUT_MAX) begin
            w_outClamp = '1;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_nextState = ST_HP;
            ST_HP:   w_nextState = ST_BP;
            ST_BP:   w_nextState = ST_LP;
            ST_LP:   w_nextState = w_lastCh ? ST_MIX : ST_HP;
            ST_MIX:  w_nextState = ST_VOL;
            ST_VOL:  w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Bypassed channels still walk HP/BP/LP so frame latency stays constant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample    <= '0;
            r_fc        <= '0;
            r_q         <= '0;
            r_mode      <= '0;
            r_filtEn    <= '0;
            r_vol       <= '0;
            r_ch        <= '0;
            r_hp        <= '0;
            r_bpNew     <= '0;
            r_acc       <= '0;
            r_mix       <= '0;
            r_outSample <= OUT_MID[IN_W-1:0];
            r_outValid  <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                r_bp[k] <= '0;
                r_lp[k] <= '0;
            end
        end else begin
            r_outValid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sample <= in_sample;
                        r_fc     <= fc;
                        r_q      <= 4'd15 - res;
                        r_mode   <= mode;
                        r_filtEn <= filt_en;
                        r_vol    <= vol;
                        r_ch     <= '0;
                        r_acc    <= '0;
                    end
                end
                ST_HP: r_hp <= w_hpSat;
                ST_BP: r_bpNew <= w_bpSat;
                ST_LP: begin
                    if (!w_bypass) begin
                        r_bp[r_ch] <= r_bpNew;
                        r_lp[r_ch] <= w_lpSat;
                    end
                    r_acc <= r_acc + w_contrib;
                    r_ch  <= r_ch + CH_W'(1);
                end
                ST_MIX: r_mix <= satState(SUM_W'(r_acc));
                ST_VOL: begin
                    r_outSample <= w_outClamp;
                    r_outValid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = r_outValid;
    assign out_sample = r_outSample;

endmodule

// File: tb/tb_svf_mux.sv
// Self-checking bench for svf_mux: directed scenarios plus randomized frames
// compared against an integer reference model of the filter equations.
module tb_svf_mux;

    localparam int NCH = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_sample;
    logic [10:0] fc;
    logic [3:0]  res;
    logic [2:0]  mode;
    logic [2:0]  filt_en;
    logic [3:0]  vol;
    logic        out_valid;
    logic [7:0]  out_sample;

    int testCount = 0;
    int failCount = 0;

    longint mBp [NCH];
    longint mLp [NCH];

    svf_mux dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
        .fc         (fc),
        .res        (res),
        .mode       (mode),
        .filt_en    (filt_en),
        .vol        (vol),
        .out_valid  (out_valid),
        .out_sample (out_sample)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic longint sat16(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < NCH; k++) begin
            mBp[k] = 0;
            mLp[k] = 0;
        end
    endtask

    // One frame of the filter equations in plain integer arithmetic.
    task automatic modelFrame(input logic [23:0] smp, input int fcv, input int resv,
                              input int modev, input logic [2:0] filt, input int volv,
                              output int outv);
        longint acc, sIn, hp, bpN, lpN, q, m, scaled, o;
        logic [23:0] s;
        s = smp;
        acc = 0;
        q = 15 - resv;
        for (int k = 0; k < NCH; k++) begin
            sIn = longint'(s[k*8 +: 8]) - 128;
            if (!filt[k] || modev == 0) begin
                acc += sIn;
            end else begin
                hp  = sat16(sIn - mLp[k] - ((mBp[k] * q) >>> 3));
                bpN = sat16(mBp[k] + ((fcv * hp) >>> 12));
                lpN = sat16(mLp[k] + ((fcv * bpN) >>> 12));
                mBp[k] = bpN;
                mLp[k] = lpN;
                if (modev[0]) acc += lpN;
                if (modev[1]) acc += bpN;
                if (modev[2]) acc += hp;
            end
        end
        m = sat16(acc);
        scaled = (m * volv) >>> 4;
        o = scaled + 128;
        if (o < 0) o = 0;
        if (o > 255) o = 255;
        outv = int'(o);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        modelReset();
    endtask

    // Waits from just after an accept edge for the output pulse, counting busy cycles.
    task automatic waitOutput(input logic countFirst, output int lat, output int lowCnt);
        lowCnt = (countFirst && !in_ready) ? 1 : 0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
            if (!in_ready) lowCnt++;
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [23:0] smp, input int fcv,
                                 input int resv, input int modev, input logic [2:0] filt,
                                 input int volv, output int observed);
        int expected, lat, lowCnt;
        modelFrame(smp, fcv, resv, modev, filt, volv, expected);
        @(negedge clk);
        in_sample = smp;
        fc        = 11'(fcv);
        res       = 4'(resv);
        mode      = 3'(modev);
        filt_en   = filt;
        vol       = 4'(volv);
        in_valid  = 1'b1;
        checkOutput({tag, "_ready"}, 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_sample = 24'($urandom);
        fc        = 11'($urandom);
        res       = 4'($urandom);
        mode      = 3'($urandom);
        filt_en   = 3'($urandom);
        vol       = 4'($urandom);
        waitOutput(1'b1, lat, lowCnt);
        checkOutput({tag, "_lat"}, 32'(lat), 11);
        checkOutput({tag, "_busy"}, 32'(lowCnt), 11);
        checkOutput({tag, "_out"}, 32'(out_sample), 32'(expected));
        observed = int'(out_sample);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int obs, prev, lat, lowCnt, expected, pulses;
        rst = 1'b1;
        in_valid = 1'b0;
        in_sample = '0;
        fc = '0;
        res = '0;
        mode = '0;
        filt_en = '0;
        vol = '0;

        doReset();
        checkOutput("reset_out", 32'(out_sample), 128);
        checkOutput("reset_valid", 32'(out_valid), 0);
        checkOutput("reset_ready", 32'(in_ready), 1);

        applyStimulus("bypass", {8'd128, 8'd128, 8'd200}, 0, 0, 1, 3'b000, 15, obs);
        checkOutput("bypass_const", 32'(obs), 195);
        @(posedge clk);
        #1;
        checkOutput("pulse_width", 32'(out_valid), 0);
        checkOutput("out_hold", 32'(out_sample), 195);

        applyStimulus("clamp_hi", {8'd255, 8'd255, 8'd255}, 0, 0, 1, 3'b000, 15, obs);
        checkOutput("clamp_hi_const", 32'(obs), 255);
        applyStimulus("clamp_lo", {8'd0, 8'd0, 8'd0}, 0, 0, 1, 3'b000, 15, obs);
        checkOutput("clamp_lo_const", 32'(obs), 0);
        applyStimulus("vol_zero", 24'($urandom), 2047, 0, 1, 3'b000, 0, obs);
        checkOutput("vol_zero_const", 32'(obs), 128);

        doReset();
        prev = 0;
        for (int f = 0; f < 18; f++) begin
            applyStimulus("lp_step", {8'd128, 8'd128, 8'd255}, 2047, 0, 1, 3'b001, 15, obs);
            if (f == 0) checkOutput("lp_first", 32'(obs), 157);
            else checkOutput("lp_mono", 32'(obs >= prev), 1);
            if (f == 17) checkOutput("lp_settle", 32'(obs), 32'(prev));
            prev = obs;
        end

        doReset();
        @(negedge clk);
        in_sample = {8'd128, 8'd128, 8'd255};
        fc = 11'd2047;
        res = 4'd0;
        mode = 3'b001;
        filt_en = 3'b001;
        vol = 4'd15;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        for (int f = 0; f < 3; f++) begin
            modelFrame({8'd128, 8'd128, 8'd255}, 2047, 0, 1, 3'b001, 15, expected);
            waitOutput(f == 0, lat, lowCnt);
            if (f == 2) in_valid = 1'b0;
            checkOutput("hold_period", 32'(lat), (f == 0) ? 11 : 12);
            checkOutput("hold_busy", 32'(lowCnt), 11);
            checkOutput("hold_out", 32'(out_sample), 32'(expected));
        end

        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        modelReset();
        checkOutput("abort_ready", 32'(in_ready), 1);
        checkOutput("abort_out", 32'(out_sample), 128);
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        checkOutput("abort_no_pulse", 32'(pulses), 0);
        applyStimulus("abort_retry", {8'd128, 8'd128, 8'd255}, 2047, 0, 1, 3'b001, 15, obs);
        checkOutput("abort_retry_const", 32'(obs), 157);

        for (int f = 0; f < 24; f++) begin
            applyStimulus("random", 24'($urandom), int'($urandom_range(0, 2047)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                          3'($urandom), int'($urandom_range(0, 15)), obs);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
